// File: rtl/chandrakanth_pkg.sv
// Shared types and pin map for the bit-serial subtractor tile.
// SUB_COMPARE_EN adds the eq/lt compare flags on uio_out[5:4].
package chandrakanth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ui_in bit positions
    localparam int UI_X     = 0;
    localparam int UI_Y     = 1;
    localparam int UI_VALID = 2;
    localparam int UI_START = 3;

    // uio_out bit positions
    localparam int UO_BORROW = 0;
    localparam int UO_DONE   = 1;
    localparam int UO_BUSY   = 2;
    localparam int UO_LAST   = 3;
    localparam int UO_EQ     = 4;
    localparam int UO_LT     = 5;

    localparam logic [7:0] UIO_OE_BASE = 8'h0F;
    localparam logic [7:0] UIO_OE_CMP  = 8'h3F;

endpackage

// File: rtl/chandrakanth_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module chandrakanth_full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic xy_w;

    assign xy_w   = x_i ^ y_i;
    assign d_o    = xy_w ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~xy_w & bin_i);

endmodule

// File: rtl/tt_um_chandrakanth_serial_subtractor.sv
// Bit-serial subtractor tile, LSB first, borrow held in a flip-flop.
// Optional SUB_COMPARE_EN macro adds registered eq/lt compare flags.
module tt_um_chandrakanth_serial_subtractor
    import chandrakanth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q;
    logic [2:0]         count_q;
    logic               borrow_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic [WIDTH-1:0]   diff_d;

    logic x_w;
    logic y_w;
    logic valid_w;
    logic start_w;
    logic d_w;
    logic bout_w;
    logic last_bit_w;

    assign x_w     = ui_in[UI_X];
    assign y_w     = ui_in[UI_Y];
    assign valid_w = ui_in[UI_VALID];
    assign start_w = ui_in[UI_START];

    assign last_bit_w = (count_q == 3'(WIDTH - 1));

    chandrakanth_full_subtractor u_fs (
        .x_i    (x_w),
        .y_i    (y_w),
        .bin_i  (borrow_q),
        .d_o    (d_w),
        .bout_o (bout_w)
    );

    // New bit enters at the MSB; the word settles LSB-aligned after WIDTH bits
    always_comb begin
        diff_d = diff_q;
        for (int i = 0; i < WIDTH - 1; i++) begin
            diff_d[i] = diff_q[i+1];
        end
        diff_d[WIDTH-1] = d_w;
    end

`ifdef SUB_COMPARE_EN
    logic eq_q;
    logic lt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            borrow_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
`ifdef SUB_COMPARE_EN
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
`endif
        end else if (start_w) begin
            // Start wins in every state; a same-cycle bit is dropped
            state_q  <= ST_RUN;
            count_q  <= '0;
            borrow_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            diff_q   <= '0;
`ifdef SUB_COMPARE_EN
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (valid_w) begin
                        diff_q   <= diff_d;
                        borrow_q <= bout_w;
                        last_q   <= d_w;
                        count_q  <= count_q + 3'd1;
                        if (last_bit_w) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            count_q <= '0;
`ifdef SUB_COMPARE_EN
                            eq_q    <= (diff_d == '0) && !bout_w;
                            lt_q    <= bout_w;
`endif
                        end
                    end
                end
                ST_IDLE: ;
                ST_DONE: ;
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out = 8'(diff_q);

    always_comb begin
        uio_out            = '0;
        uio_out[UO_BORROW] = borrow_q;
        uio_out[UO_DONE]   = done_q;
        uio_out[UO_BUSY]   = busy_q;
        uio_out[UO_LAST]   = last_q;
`ifdef SUB_COMPARE_EN
        uio_out[UO_EQ]     = eq_q;
        uio_out[UO_LT]     = lt_q;
`endif
    end

`ifdef SUB_COMPARE_EN
    assign uio_oe = UIO_OE_CMP;
`else
    assign uio_oe = UIO_OE_BASE;
`endif

    wire _unused = &{1'b0, ena, uio_in, ui_in[7:4], 1'b0};

endmodule

// File: tb/tb_tt_um_chandrakanth_serial_subtractor.sv
// Directed bench for the serial subtractor tile.
// Drives on the falling edge, samples on the falling edge.
module tb_tt_um_chandrakanth_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SUB_COMPARE_EN
    localparam logic [7:0] OE_EXP = 8'h3F;
`else
    localparam logic [7:0] OE_EXP = 8'h0F;
`endif

    tt_um_chandrakanth_serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        ui_in[3] = 1'b1;
        @(negedge clk);
        ui_in[3] = 1'b0;
    endtask

    task automatic send_bits(
        input logic [7:0] a,
        input logic [7:0] b,
        input int         lo,
        input int         hi,
        input int         maxgap
    );
        for (int i = lo; i <= hi; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            ui_in[0] = a[i];
            ui_in[1] = b[i];
            ui_in[2] = 1'b1;
            @(negedge clk);
            ui_in[2] = 1'b0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, OE_EXP);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_uio", uio_out, 8'h00);

        // 0x05 - 0x03
        do_start();
        check("start_busy", uio_out[3:0], 4'b0100);
        send_bits(8'h05, 8'h03, 0, 6, 0);
        check("p1_not_done", uio_out[1], 1'b0);
        send_bits(8'h05, 8'h03, 7, 7, 0);
        check("p1_uo", uo_out, 8'h02);
        check("p1_flags", uio_out[3:0], 4'b0010);
        check("p1_hi", uio_out[7:6], 2'b00);
`ifdef SUB_COMPARE_EN
        check("p1_cmp", uio_out[5:4], 2'b00);
`else
        check("p1_cmp0", uio_out[5:4], 2'b00);
`endif

        // 0x03 - 0x05, with a mid-word look
        do_start();
        send_bits(8'h03, 8'h05, 0, 1, 0);
        check("p2_mid_uo", uo_out, 8'h80);
        check("p2_mid_b", uio_out[0], 1'b0);
        send_bits(8'h03, 8'h05, 2, 2, 0);
        check("p2_mid_b2", uio_out[0], 1'b1);
        send_bits(8'h03, 8'h05, 3, 7, 0);
        check("p2_uo", uo_out, 8'hFE);
        check("p2_flags", uio_out[3:0], 4'b1011);
`ifdef SUB_COMPARE_EN
        check("p2_cmp", uio_out[5:4], 2'b10);
`endif
        // DONE ignores bit_valid
        send_bits(8'hFF, 8'h00, 0, 0, 0);
        check("p2_hold", uo_out, 8'hFE);

        // 0xA7 - 0xA7 with gaps
        do_start();
        send_bits(8'hA7, 8'hA7, 0, 7, 3);
        check("p3_uo", uo_out, 8'h00);
        check("p3_flags", uio_out[3:0], 4'b0010);
`ifdef SUB_COMPARE_EN
        check("p3_cmp", uio_out[5:4], 2'b01);
`endif

        // restart mid-word with a colliding bit
        do_start();
        send_bits(8'h55, 8'h22, 0, 3, 0);
        ui_in[0] = 1'b1;
        ui_in[1] = 1'b0;
        ui_in[2] = 1'b1;
        do_start();
        ui_in[2] = 1'b0;
        check("p4_clr_uo", uo_out, 8'h00);
        check("p4_clr_f", uio_out[3:0], 4'b0100);
        send_bits(8'h10, 8'h01, 0, 7, 0);
        check("p4_uo", uo_out, 8'h0F);
        check("p4_flags", uio_out[3:0], 4'b0010);

        // async reset mid-word
        do_start();
        send_bits(8'h6B, 8'h1C, 0, 4, 0);
        rst_n = 1'b0;
        #1;
        check("p5_rst_uo", uo_out, 8'h00);
        check("p5_rst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        // IDLE ignores bit_valid
        send_bits(8'hFF, 8'h00, 0, 0, 0);
        check("p5_idle_uo", uo_out, 8'h00);
        check("p5_idle_f", uio_out, 8'h00);
        do_start();
        send_bits(8'hFF, 8'h00, 0, 7, 0);
        check("p5_uo", uo_out, 8'hFF);
        check("p5_flags", uio_out[3:0], 4'b1010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
